data_mem_param: RTL
===================

Name: data_mem_param

Overview:
- Parametrised successor of the encoder data memory: WIDTH-bit words, DEPTH entries.
- Registered (1-cycle) read port with valid flag, independent write port.
- Sequenced bulk-clear engine with busy flag.
- Flattened snapshot bus exposing every entry to the encoder datapath, e.g. the 64x25 lane array.

Parameters:
- WIDTH, 25, bits per word.
- DEPTH, 64, number of entries (need not be a power of 2).
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  single-cycle pulse; starts bulk clear.
- busy  out  1  high while bulk clear is in progress.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  WIDTH  write data.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  WIDTH  registered read data.
- rd_valid  out  1  rd_data updated this cycle.
- snap_out  out  DEPTH*WIDTH  all entries; entry i at bits [i*WIDTH +: WIDTH].

Behaviour:
- Reset is asynchronous and active-high.
  - All entries go to 0; rd_data=0, rd_valid=0, busy=0.
  - FSM goes to IDLE; clear counter goes to 0.
  - Reset mid-clear aborts the clear; array is zeroed by the reset itself.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clear=1. busy rises the next cycle.
  - CLEAR writes 0 to entry cnt each cycle; cnt runs 0..DEPTH-1.
  - CLEAR -> IDLE after entry DEPTH-1 is written. busy is high exactly DEPTH cycles.
  - clear asserted while in CLEAR is ignored (no restart).
- Write port:
  - On posedge with wr_en=1, busy=0 and wr_addr<DEPTH: mem[wr_addr] <= wr_data.
  - wr_addr>=DEPTH: write dropped silently.
  - During busy: write dropped.
  - wr_en in the same cycle as a clear pulse accepted in IDLE: the write commits, then the clear erases it.
- Read port:
  - Latency 1. With rd_en=1 and busy=0 at edge N: rd_data = mem[rd_addr] and rd_valid=1 after edge N.
  - rd_valid=0 in any cycle without an accepted read; rd_data holds its last value.
  - rd_addr>=DEPTH: rd_data=0, rd_valid=1.
  - rd_en during busy: not accepted, rd_valid=0.
- Same-address read and write in one cycle: read-first; rd_data returns the old contents. The optional feature changes this.
- snap_out reflects array contents after each edge (register outputs, no added latency). It updates during clear as entries zero.
- Back-to-back reads and writes are supported every cycle; no stall outside busy.

Optional Feature:
- Macro: DATA_MEM_FWD_EN.
- Defined: a same-cycle, same-address accepted read and write returns wr_data on rd_data (write-through forwarding).
- Undefined: read-first; returns the pre-write value.
- All other behaviour is identical with or without the macro.

Decomposition:
- Package data_mem_pkg holds:
  - localparams for the default WIDTH (25) and DEPTH (64);
  - enum typedef for the FSM state (IDLE, CLEAR);
  - helper function for the snap_out slice offset.
- One natural sub-module: data_mem_clr_seq, the clear FSM plus counter. It outputs busy, clr_we and clr_addr.
- The array, read register and forwarding logic stay in the top module.

Test Plan:
1. Reset with defaults, then write 0x1ABCDEF to addr 5. Read addr 5 next cycle -> rd_valid=1 one cycle later, rd_data=0x1ABCDEF; snap_out[125+:25]=0x1ABCDEF.
2. Fill all 64 entries with value=addr, then pulse clear -> busy high exactly 64 cycles; snap_out all-zero after busy falls; reads and writes issued during busy are ignored, with rd_valid=0.
3. Write 0x0000AAA to addr 9, then same-cycle write 0x1555555 and read at addr 9 -> rd_data=0x0000AAA without DATA_MEM_FWD_EN; 0x1555555 with it.
4. DEPTH=50: write to addr 60 -> array unchanged; read addr 60 -> rd_valid=1, rd_data=0.
5. Pulse clear, then assert rst at busy cycle 20 -> busy=0 immediately, all entries 0, FSM IDLE; a new clear afterwards runs the full 64 cycles.
6. WIDTH=32, DEPTH=16: random writes and reads over 1000 cycles checked against a reference model -> no mismatches; rd_valid matches delayed rd_en.

Source files
------------

// File: rtl/data_mem_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_pkg
// Shared definitions for the parametrised encoder data memory.
//   DEF_WIDTH / DEF_DEPTH : default word width and entry count.
//   clr_state_t           : bulk-clear FSM state encoding (IDLE, CLEAR).
//   snap_off()            : bit offset of entry idx on the flattened snapshot bus.
// -----------------------------------------------------------------------------
package data_mem_pkg;

   localparam int DEF_WIDTH = 25;
   localparam int DEF_DEPTH = 64;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_t;

   // Entry idx occupies snap_out[snap_off(idx, width) +: width].
   function automatic int snap_off(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/data_mem_if.sv
// -----------------------------------------------------------------------------
// data_mem_if
// Bus bundle between the encoder datapath (master) and data_mem_param (slave).
//   clear            : single-cycle pulse starting a bulk clear
//   busy             : bulk clear in progress
//   wr_en/addr/data  : write port
//   rd_en/addr       : read request
//   rd_data/rd_valid : registered read result (1-cycle latency)
//   snap_out         : every entry, flattened, entry i at [i*WIDTH +: WIDTH]
//   clr_state        : debug view of the bulk-clear FSM state
//
// Handshake: busy is the inverse of ready for both ports. A write or read is
// accepted on a posedge where its enable is high and busy is low; otherwise it
// is dropped (no retry, no stall). rd_valid is high for exactly the cycle after
// an accepted read and marks rd_data as freshly updated.
// -----------------------------------------------------------------------------
interface data_mem_if #(
   parameter int WIDTH = data_mem_pkg::DEF_WIDTH,
   parameter int DEPTH = data_mem_pkg::DEF_DEPTH
);
   import data_mem_pkg::*;

   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic                   clear;
   logic                   busy;
   logic                   wr_en;
   logic [ADDR_W-1:0]      wr_addr;
   logic [WIDTH-1:0]       wr_data;
   logic                   rd_en;
   logic [ADDR_W-1:0]      rd_addr;
   logic [WIDTH-1:0]       rd_data;
   logic                   rd_valid;
   logic [DEPTH*WIDTH-1:0] snap_out;
   clr_state_t             clr_state;

   modport master (
      output clear, wr_en, wr_addr, wr_data, rd_en, rd_addr,
      input  busy, rd_data, rd_valid, snap_out, clr_state
   );

   modport slave (
      input  clear, wr_en, wr_addr, wr_data, rd_en, rd_addr,
      output busy, rd_data, rd_valid, snap_out, clr_state
   );

endinterface

// File: rtl/data_mem_clr_seq.sv
// -----------------------------------------------------------------------------
// data_mem_clr_seq
// Bulk-clear sequencer: on a clear pulse in IDLE it walks cnt = 0..DEPTH-1,
// asking the array to zero one entry per cycle, then returns to IDLE.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : start pulse (ignored while already clearing)
//   busy      : high for exactly DEPTH cycles per clear
//   clr_we    : zero-write strobe for the array
//   clr_addr  : entry to zero this cycle
//   state     : current FSM state (debug)
// -----------------------------------------------------------------------------
module data_mem_clr_seq
   import data_mem_pkg::*;
#(
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   output logic              busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr,
   output clr_state_t        state
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   clr_state_t        state_nxt;
   logic [ADDR_W-1:0] cnt;
   logic [ADDR_W-1:0] cnt_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (clear) begin
               state_nxt = CLEAR;
               cnt_nxt   = '0;
            end
         end
         CLEAR: begin
            // clear is deliberately not looked at here: no restart mid-sweep.
            if (cnt == LAST) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      busy     = (state == CLEAR);
      clr_we   = (state == CLEAR);
      clr_addr = cnt;
   end

endmodule

// File: rtl/data_mem_param.sv
// -----------------------------------------------------------------------------
// data_mem_param
// Parametrised encoder data memory: DEPTH words of WIDTH bits, a registered
// read port with valid flag, an independent write port, a sequenced bulk
// clear, and a flattened snapshot of every entry for the encoder datapath.
// Ports:
//   clk  : system clock, all state updates on posedge
//   rst  : asynchronous active-high reset (zeroes array, aborts any clear)
//   bus  : data_mem_if.slave (clear/busy, write port, read port, snap_out,
//          clr_state debug)
// Build option:
//   DATA_MEM_FWD_EN defined   -> same-address read+write in one cycle returns
//                                the new wr_data (write-through forwarding).
//   DATA_MEM_FWD_EN undefined -> read-first: the pre-write contents are read.
// -----------------------------------------------------------------------------
module data_mem_param
   import data_mem_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic     clk,
   input  logic     rst,
   data_mem_if.slave bus
);

   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // One extra bit so DEPTH itself is representable for the range checks.
   localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

   logic [WIDTH-1:0]       mem [DEPTH];
   logic                   busy;
   logic                   clr_we;
   logic [ADDR_W-1:0]      clr_addr;
   clr_state_t             clr_state;

   logic                   wr_ok;
   logic                   rd_ok;
   logic                   rd_in_range;
   logic [WIDTH-1:0]       rd_word;
   logic [WIDTH-1:0]       rd_data_q;
   logic                   rd_valid_q;
   logic [DEPTH*WIDTH-1:0] snap;

   data_mem_clr_seq #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_clr_seq (
      .clk      (clk),
      .rst      (rst),
      .clear    (bus.clear),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr),
      .state    (clr_state)
   );

   always_comb begin
      wr_ok       = bus.wr_en && !busy && ({1'b0, bus.wr_addr} < DEPTH_L);
      rd_ok       = bus.rd_en && !busy;
      rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_L);
   end

   // Read word selection; out-of-range reads return zero but still complete.
   always_comb begin
      rd_word = '0;
      if (rd_in_range) begin
         rd_word = mem[bus.rd_addr];
      end
`ifdef DATA_MEM_FWD_EN
      if (wr_ok && (bus.wr_addr == bus.rd_addr)) begin
         rd_word = bus.wr_data;
      end
`endif
   end

   // Array. The clear sweep and user writes never overlap because user writes
   // are only accepted while busy is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (clr_we) begin
         mem[clr_addr] <= '0;
      end else if (wr_ok) begin
         mem[bus.wr_addr] <= bus.wr_data;
      end
   end

   // Registered read port; rd_data holds between accepted reads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_ok;
         if (rd_ok) begin
            rd_data_q <= rd_word;
         end
      end
   end

   always_comb begin
      snap = '0;
      for (int i = 0; i < DEPTH; i++) begin
         snap[snap_off(i, WIDTH) +: WIDTH] = mem[i];
      end
   end

   assign bus.busy      = busy;
   assign bus.rd_data   = rd_data_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.snap_out  = snap;
   assign bus.clr_state = clr_state;

endmodule
